// File: rtl/proc_pkg.sv
// ============================================================================
//  Module      : proc_pkg
//  Description : Shared phase-sequencer types and defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package proc_pkg;

    typedef enum logic [2:0] {
        S_F    = 3'd0,
        S_E    = 3'd1,
        S_M    = 3'd2,
        S_W    = 3'd3,
        S_HALT = 3'd4
    } phase_state_t;

    localparam int TIMEOUT_DEFAULT = 16;

endpackage

`default_nettype wire

// File: rtl/proc_phase_gen_edge_detect.sv
// ============================================================================
//  Module      : edge_detect
//  Description : Flags any level change of din relative to the previous cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic edge_pulse
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= din;
        end
    end

    assign edge_pulse = (din != d_q);

endmodule

`default_nettype wire

// File: rtl/proc_phase_gen.sv
// ============================================================================
//  Module      : proc_phase_gen
//  Description : Turns divider edges into fetch/exec/mem/wb strobes, with
//                halt/step control, a divider-loss watchdog and an optional
//                retired-instruction counter (PHASE_GEN_RETIRE_CNT_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module proc_phase_gen
    import proc_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_clk,
    input  logic             halt_req,
    input  logic             step_req,
    output logic             ph_fetch,
    output logic             ph_exec,
    output logic             ph_mem,
    output logic             ph_wb,
    output logic             halted,
    output logic             div_lost
`ifdef PHASE_GEN_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retired_cnt
`endif
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] c_wd_max = WD_W'(TIMEOUT);

    logic            w_edge;
    phase_state_t    r_state;
    logic            r_step_pend;
    logic            r_ph_fetch;
    logic            r_ph_exec;
    logic            r_ph_mem;
    logic            r_ph_wb;
    logic [WD_W-1:0] r_wd_cnt;
    logic [WD_W-1:0] w_wd_next;
    logic            r_div_lost;
    logic            w_exit_halt;

    edge_detect u_edge_detect (
        .clk        (clk),
        .reset      (reset),
        .din        (div_clk),
        .edge_pulse (w_edge)
    );

    assign w_exit_halt = (r_state == S_HALT) && w_edge && (!halt_req || r_step_pend);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_F;
            r_ph_fetch <= 1'b0;
            r_ph_exec  <= 1'b0;
            r_ph_mem   <= 1'b0;
            r_ph_wb    <= 1'b0;
        end else begin
            r_ph_fetch <= 1'b0;
            r_ph_exec  <= 1'b0;
            r_ph_mem   <= 1'b0;
            r_ph_wb    <= 1'b0;
            case (r_state)
                S_F: if (w_edge) begin
                    r_ph_fetch <= 1'b1;
                    r_state    <= S_E;
                end
                S_E: if (w_edge) begin
                    r_ph_exec <= 1'b1;
                    r_state   <= S_M;
                end
                S_M: if (w_edge) begin
                    r_ph_mem <= 1'b1;
                    r_state  <= S_W;
                end
                S_W: if (w_edge) begin
                    r_ph_wb <= 1'b1;
                    r_state <= halt_req ? S_HALT : S_F;
                end
                S_HALT: if (w_exit_halt) begin
                    r_ph_fetch <= 1'b1;
                    r_state    <= S_E;
                end
                default: r_state <= S_F;
            endcase
        end
    end

    // A step request arriving on the exit edge is absorbed by that exit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_step_pend <= 1'b0;
        end else if (w_exit_halt) begin
            r_step_pend <= 1'b0;
        end else if (step_req && (r_state == S_HALT)) begin
            r_step_pend <= 1'b1;
        end
    end

    assign w_wd_next = w_edge ? '0 :
                       (r_wd_cnt == c_wd_max) ? c_wd_max : r_wd_cnt + WD_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd_cnt   <= '0;
            r_div_lost <= 1'b0;
        end else begin
            r_wd_cnt <= w_wd_next;
            if (w_wd_next == c_wd_max) begin
                r_div_lost <= 1'b1;
            end
        end
    end

`ifdef PHASE_GEN_RETIRE_CNT_EN
    logic [CNT_W-1:0] r_retired_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired_cnt <= '0;
        end else if (r_ph_wb) begin
            r_retired_cnt <= r_retired_cnt + CNT_W'(1);
        end
    end

    assign retired_cnt = r_retired_cnt;
`else
    // Retire counter not built.
`endif

    assign ph_fetch = r_ph_fetch;
    assign ph_exec  = r_ph_exec;
    assign ph_mem   = r_ph_mem;
    assign ph_wb    = r_ph_wb;
    assign halted   = (r_state == S_HALT);
    assign div_lost = r_div_lost;

endmodule

`default_nettype wire

// File: tb/tb_proc_phase_gen.sv
// ============================================================================
//  Module      : tb_proc_phase_gen
//  Description : Directed vector bench for proc_phase_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_proc_phase_gen;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 32;

    localparam logic [3:0] PF = 4'b1000;
    localparam logic [3:0] PE = 4'b0100;
    localparam logic [3:0] PM = 4'b0010;
    localparam logic [3:0] PW = 4'b0001;
    localparam logic [3:0] P0 = 4'b0000;

    logic clk = 1'b0;
    logic reset;
    logic div_clk;
    logic halt_req;
    logic step_req;
    logic ph_fetch, ph_exec, ph_mem, ph_wb;
    logic halted;
    logic div_lost;
`ifdef PHASE_GEN_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_cnt;
`endif

    always #5 clk = ~clk;

    proc_phase_gen #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .div_clk     (div_clk),
        .halt_req    (halt_req),
        .step_req    (step_req),
        .ph_fetch    (ph_fetch),
        .ph_exec     (ph_exec),
        .ph_mem      (ph_mem),
        .ph_wb       (ph_wb),
        .halted      (halted),
        .div_lost    (div_lost)
`ifdef PHASE_GEN_RETIRE_CNT_EN
        ,
        .retired_cnt (retired_cnt)
`endif
    );

    typedef struct {
        logic        dclk;
        logic        h;
        logic        s;
        logic [3:0]  ph;
        logic        hl;
        logic        lost;
        int unsigned cnt;
    } vec_t;

    vec_t        vecs[$];
    logic        b_dc;
    int unsigned b_cnt;
    int          n_checks;
    int          n_fail;

    // tog toggles div_clk for this cycle; cnt expectation follows W strobes.
    task automatic add(input logic tog, input logic h, input logic s,
                       input logic [3:0] ph, input logic hl, input logic lost);
        vec_t v;
        if (tog) b_dc = ~b_dc;
        v.dclk = b_dc;
        v.h    = h;
        v.s    = s;
        v.ph   = ph;
        v.hl   = hl;
        v.lost = lost;
        v.cnt  = b_cnt;
        vecs.push_back(v);
        if (ph[0]) b_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ph, input logic hl,
                           input logic lost, input int unsigned cnt);
        chk({tag, " strobes"}, {28'd0, ph_fetch, ph_exec, ph_mem, ph_wb}, {28'd0, ph});
        chk({tag, " halted"}, {31'd0, halted}, {31'd0, hl});
        chk({tag, " div_lost"}, {31'd0, div_lost}, {31'd0, lost});
`ifdef PHASE_GEN_RETIRE_CNT_EN
        chk({tag, " retired_cnt"}, retired_cnt, cnt);
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        b_dc     = 1'b0;
        b_cnt    = 0;

        // Free run two instructions; a stray step_req must be ignored.
        add(1,0,0,PF,0,0); add(0,0,0,P0,0,0);
        add(1,0,0,PE,0,0); add(0,0,1,P0,0,0);
        add(1,0,0,PM,0,0); add(0,0,0,P0,0,0);
        add(1,0,0,PW,0,0); add(0,0,0,P0,0,0);
        add(1,0,0,PF,0,0); add(0,0,0,P0,0,0);
        add(1,0,0,PE,0,0); add(0,0,0,P0,0,0);
        add(1,0,0,PM,0,0); add(0,0,0,P0,0,0);
        add(1,0,0,PW,0,0); add(0,0,0,P0,0,0);
        // Halt requested from the E strobe.
        add(1,0,0,PF,0,0); add(0,0,0,P0,0,0);
        add(1,1,0,PE,0,0); add(0,1,0,P0,0,0);
        add(1,1,0,PM,0,0); add(0,1,0,P0,0,0);
        add(1,1,0,PW,1,0); add(0,1,0,P0,1,0);
        for (int i = 0; i < 10; i++) begin
            add(1,1,0,P0,1,0); add(0,1,0,P0,1,0);
        end
        // Single step while halt_req stays high.
        add(0,1,1,P0,1,0);
        add(1,1,0,PF,0,0); add(0,1,0,P0,0,0);
        add(1,1,0,PE,0,0); add(0,1,0,P0,0,0);
        add(1,1,0,PM,0,0); add(0,1,0,P0,0,0);
        add(1,1,0,PW,1,0); add(0,1,0,P0,1,0);
        add(1,1,0,P0,1,0); add(0,1,0,P0,1,0);
        add(1,1,0,P0,1,0); add(0,1,0,P0,1,0);
        // Release halt; a halt pulse that falls before W does nothing.
        add(1,0,0,PF,0,0); add(0,0,0,P0,0,0);
        add(1,0,0,PE,0,0); add(0,1,0,P0,0,0);
        add(1,0,0,PM,0,0); add(0,0,0,P0,0,0);
        add(1,0,0,PW,0,0); add(0,0,0,P0,0,0);
        add(1,0,0,PF,0,0);
        // Divider stops: flag rises on the 16th quiet cycle after the edge.
        for (int i = 1; i < TIMEOUT; i++) add(0,0,0,P0,0,0);
        add(0,0,0,P0,0,1);
        add(0,0,0,P0,0,1);
        add(1,0,0,PE,0,1); add(0,0,0,P0,0,1);
        add(1,0,0,PM,0,1);

        reset    = 1'b1;
        div_clk  = 1'b0;
        halt_req = 1'b0;
        step_req = 1'b0;
        tick();
        tick();
        chk_all("reset", P0, 1'b0, 1'b0, 0);
        reset = 1'b0;
        tick();
        chk_all("post-reset idle", P0, 1'b0, 1'b0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            div_clk  = vecs[i].dclk;
            halt_req = vecs[i].h;
            step_req = vecs[i].s;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].ph, vecs[i].hl, vecs[i].lost, vecs[i].cnt);
        end

        // Reset between M and W: instruction abandoned, restart at fetch.
        reset   = 1'b1;
        div_clk = 1'b0;
        tick();
        chk_all("mid reset", P0, 1'b0, 1'b0, 0);
        reset = 1'b0;
        tick();
        chk_all("mid reset release", P0, 1'b0, 1'b0, 0);
        div_clk = 1'b1;
        tick();
        chk_all("first edge after reset", PF, 1'b0, 1'b0, 0);
        tick();
        chk_all("gap after reset", P0, 1'b0, 1'b0, 0);
        div_clk = 1'b0;
        tick();
        chk_all("second edge after reset", PE, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
